// File: rtl/param_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | param_stack : parametrised LIFO stack on a shared tri-state datapath bus |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module param_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    inout  wire  [WIDTH-1:0]           bus,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic                       i_s,
    output logic [WIDTH-1:0]           o_top,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    logic             empty;
    logic             full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             set_ovf;
    logic             set_unf;
    logic             flush;
    logic             wr_en;

    // Indices are narrowed to the array width; out-of-range values only occur
    // in the states (empty/full) where the corresponding access is suppressed.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        top_idx    = AW'(count - CW'(1));
        push_idx   = AW'(count);
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case ({i_push, i_pop})
            2'b10: begin
                if (full) set_ovf = 1'b1;
                else      do_push = 1'b1;
            end
            2'b01: begin
                if (empty) set_unf = 1'b1;
                else       do_pop  = 1'b1;
            end
            2'b11: begin
                if (empty) set_unf    = 1'b1;
                else       do_replace = 1'b1;
            end
            default: ;
        endcase
        flush  = !i_reset_n || i_clear;
        wr_en  = !flush && (do_push || do_replace);
        wr_idx = do_replace ? top_idx : push_idx;
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) mem[wr_idx] <= bus;
    end

    always_ff @(posedge i_clock) begin
        if (flush) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push)     count <= count + CW'(1);
            else if (do_pop) count <= count - CW'(1);
            if (set_ovf) overflow  <= 1'b1;
            if (set_unf) underflow <= 1'b1;
        end
    end

    assign o_top       = empty ? '0 : mem[top_idx];
    assign o_count     = count;
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_overflow  = overflow;
    assign o_underflow = underflow;

    // Duplicate-top push works because the bus is sampled before the write lands.
    assign bus = i_s ? o_top : {WIDTH{1'bz}};

endmodule
`default_nettype wire
